// File: rtl/spi_uart_frame_bridge.sv
// Purpose: SPI-to-UART byte bridge with a FIFO and a compile-time pattern matcher (frame-aligned or sliding).
// Latency: rx_ack and match_pulse come 1 cycle after accept; a byte reaches tx_data 1 cycle after it heads a non-empty FIFO with tx_ready=1.
// Backpressure: tx_ready=0 stalls the TX FSM indefinitely; a byte accepted while the FIFO is full is dropped and overflow is set.
//
// Ports:
//   system_clk, reset         clock, asynchronous active-high reset
//   spi_cs_n                  raw SPI chip select (active low), synchronised here
//   rx_data/rx_ready/rx_ack   byte from spi_slave; rx_ack is a one-cycle accept pulse
//   tx_data/tx_start/tx_ready byte to uart_tx; tx_start is a one-cycle enqueue strobe
//   match_pulse/match_sticky  pattern match flags; match_clear clears the sticky flag
//   overflow                  sticky dropped-byte flag; fifo_level is the FIFO occupancy
module spi_uart_frame_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PATTERN_LEN = 16,
  parameter logic [PATTERN_LEN*DATA_WIDTH-1:0] PATTERN = {"SPI debug data", 8'h0D, 8'h0A},
  parameter int MATCH_MODE = 0
) (
  input  logic                          system_clk,
  input  logic                          reset,
  input  logic                          spi_cs_n,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_ready,
  output logic                          rx_ack,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_ready,
  output logic                          match_pulse,
  output logic                          match_sticky,
  input  logic                          match_clear,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int IDX_W = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
  localparam int CNT_W = $clog2(PATTERN_LEN + 1);
  localparam int PW    = PATTERN_LEN * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // ---------------- RX accept and FIFO ----------------
  logic                  accept;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [1:0]            tx_state;

  // rx_ack high masks the still-asserted rx_ready, limiting accepts to one per two cycles.
  assign accept    = rx_ready & ~rx_ack;
  // Fullness uses the pre-edge level, so a same-cycle pop never rescues the byte.
  assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));
  assign push      = accept & ~fifo_full;
  assign pop       = (tx_state == ST_IDLE) & (fifo_level != '0) & tx_ready;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      rx_ack   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_ack <= accept;
      if (accept && fifo_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge system_clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  // The GAP state gives uart_tx one cycle to update tx_ready before the next load.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_data  <= '0;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: tx_state <= ST_GAP;
        default:  tx_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start = (tx_state == ST_ISSUE);

  // ---------------- CS synchroniser ----------------
  logic cs_meta, cs_sync, cs_prev;
  logic cs_fall, cs_rise;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= spi_cs_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_fall = cs_prev & ~cs_sync;
  assign cs_rise = ~cs_prev & cs_sync;

  // ---------------- Frame-aligned matcher ----------------
  logic [DATA_WIDTH-1:0] pat_byte [PATTERN_LEN];
  logic [IDX_W-1:0]      byte_idx;
  logic                  mismatch;
  logic                  armed;
  logic                  byte_neq;
  logic                  frame_last;
  logic                  frame_hit;

  // Byte 0 of the pattern is its most significant byte.
  for (genvar i = 0; i < PATTERN_LEN; i++) begin : g_pat
    assign pat_byte[i] = PATTERN[(PATTERN_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign byte_neq   = (rx_data != pat_byte[byte_idx]);
  assign frame_last = (byte_idx == IDX_W'(PATTERN_LEN - 1));
  // CS edges take priority over a coincident byte, matching the state update below.
  assign frame_hit  = accept & armed & frame_last & ~mismatch & ~byte_neq & ~cs_fall & ~cs_rise;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      mismatch <= 1'b0;
      armed    <= 1'b0;
    end else if (cs_fall) begin
      byte_idx <= '0;
      mismatch <= 1'b0;
      armed    <= 1'b1;
    end else if (cs_rise) begin
      armed <= 1'b0;
    end else if (accept && armed) begin
      mismatch <= mismatch | byte_neq;
      if (frame_last) armed <= 1'b0;
      else            byte_idx <= byte_idx + IDX_W'(1);
    end
  end

  // ---------------- Sliding-window matcher ----------------
  logic [PW-1:0]    window;
  logic [PW-1:0]    win_next;
  logic [CNT_W-1:0] valid_cnt;
  logic             slide_hit;

  // Oldest byte sits in the MSBs, lining up with pattern byte 0.
  assign win_next  = PW'({window, rx_data});
  assign slide_hit = accept & (valid_cnt >= CNT_W'(PATTERN_LEN - 1)) & (win_next == PATTERN);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      window    <= '0;
      valid_cnt <= '0;
    end else if (accept) begin
      window <= win_next;
      if (valid_cnt != CNT_W'(PATTERN_LEN)) valid_cnt <= valid_cnt + CNT_W'(1);
    end
  end

  // ---------------- Match flags ----------------
  logic match_hit;
  assign match_hit = (MATCH_MODE == 1) ? slide_hit : frame_hit;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      match_pulse  <= 1'b0;
      match_sticky <= 1'b0;
    end else begin
      match_pulse <= match_hit;
      if (match_hit)        match_sticky <= 1'b1;
      else if (match_clear) match_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_uart_frame_bridge.sv
module tb_spi_uart_frame_bridge;

  logic       system_clk = 1'b0;
  logic       reset;
  logic       spi_cs_n;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_ready;
  logic       match_clear;

  always #5 system_clk = ~system_clk;

  // u_frame: defaults; u_slide: sliding "aba"; u_small: frame mode, 4-deep FIFO
  logic       f_rx_ack, f_tx_start, f_match_pulse, f_match_sticky, f_overflow;
  logic [7:0] f_tx_data;
  logic [4:0] f_fifo_level;
  logic       s_rx_ack, s_tx_start, s_match_pulse, s_match_sticky, s_overflow;
  logic [7:0] s_tx_data;
  logic [4:0] s_fifo_level;
  logic       m_rx_ack, m_tx_start, m_match_pulse, m_match_sticky, m_overflow;
  logic [7:0] m_tx_data;
  logic [2:0] m_fifo_level;

  spi_uart_frame_bridge u_frame (
    .system_clk(system_clk), .reset(reset), .spi_cs_n(spi_cs_n),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(f_rx_ack),
    .tx_data(f_tx_data), .tx_start(f_tx_start), .tx_ready(tx_ready),
    .match_pulse(f_match_pulse), .match_sticky(f_match_sticky), .match_clear(match_clear),
    .overflow(f_overflow), .fifo_level(f_fifo_level)
  );

  spi_uart_frame_bridge #(.PATTERN_LEN(3), .PATTERN("aba"), .MATCH_MODE(1)) u_slide (
    .system_clk(system_clk), .reset(reset), .spi_cs_n(spi_cs_n),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(s_rx_ack),
    .tx_data(s_tx_data), .tx_start(s_tx_start), .tx_ready(tx_ready),
    .match_pulse(s_match_pulse), .match_sticky(s_match_sticky), .match_clear(match_clear),
    .overflow(s_overflow), .fifo_level(s_fifo_level)
  );

  spi_uart_frame_bridge #(.FIFO_DEPTH(4)) u_small (
    .system_clk(system_clk), .reset(reset), .spi_cs_n(spi_cs_n),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(m_rx_ack),
    .tx_data(m_tx_data), .tx_start(m_tx_start), .tx_ready(tx_ready),
    .match_pulse(m_match_pulse), .match_sticky(m_match_sticky), .match_clear(match_clear),
    .overflow(m_overflow), .fifo_level(m_fifo_level)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  string      pat_f = "SPI debug data\r\n";
  string      pat_s = "aba";
  bit         fr_armed = 1'b0;
  logic [7:0] fr_buf[$];
  logic [7:0] sl_win[$];
  logic [7:0] q_f[$], q_s[$], q_m[$];
  int         exp_pf = 0, exp_ps = 0;
  int         cnt_pf = 0, cnt_ps = 0, cnt_pm = 0;
  bit         exp_sticky_f = 1'b0, exp_sticky_s = 1'b0;
  bit         exp_ovf_m = 1'b0;
  logic [7:0] fbuf[48];
  int         flen = 0;

  // UART-side scoreboard and match pulse counters
  always @(negedge system_clk) begin
    logic [7:0] e;
    if (f_tx_start) begin
      tests_run++;
      if (q_f.size() == 0) begin
        tests_failed++; $display("FAIL uart_f: unexpected tx_start data=%h", f_tx_data);
      end else begin
        e = q_f.pop_front();
        if (f_tx_data !== e) begin tests_failed++; $display("FAIL uart_f: got %h expected %h", f_tx_data, e); end
      end
    end
    if (s_tx_start) begin
      tests_run++;
      if (q_s.size() == 0) begin
        tests_failed++; $display("FAIL uart_s: unexpected tx_start data=%h", s_tx_data);
      end else begin
        e = q_s.pop_front();
        if (s_tx_data !== e) begin tests_failed++; $display("FAIL uart_s: got %h expected %h", s_tx_data, e); end
      end
    end
    if (m_tx_start) begin
      tests_run++;
      if (q_m.size() == 0) begin
        tests_failed++; $display("FAIL uart_m: unexpected tx_start data=%h", m_tx_data);
      end else begin
        e = q_m.pop_front();
        if (m_tx_data !== e) begin tests_failed++; $display("FAIL uart_m: got %h expected %h", m_tx_data, e); end
      end
    end
    if (f_match_pulse) cnt_pf++;
    if (s_match_pulse) cnt_ps++;
    if (m_match_pulse) cnt_pm++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ef, es, eq;
    @(posedge system_clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    ef = 1'b0;
    if (fr_armed) begin
      fr_buf.push_back(b);
      if (fr_buf.size() == 16) begin
        fr_armed = 1'b0;
        eq = 1'b1;
        for (int i = 0; i < 16; i++) if (fr_buf[i] != pat_f[i]) eq = 1'b0;
        ef = eq;
      end
    end
    sl_win.push_back(b);
    if (sl_win.size() > 3) void'(sl_win.pop_front());
    es = (sl_win.size() == 3) && (sl_win[0] == pat_s[0]) && (sl_win[1] == pat_s[1]) && (sl_win[2] == pat_s[2]);
    q_f.push_back(b);
    q_s.push_back(b);
    if (!tx_ready && q_m.size() >= 4) exp_ovf_m = 1'b1;
    else q_m.push_back(b);
    if (ef) begin exp_pf++; exp_sticky_f = 1'b1; end
    if (es) begin exp_ps++; exp_sticky_s = 1'b1; end
    @(posedge system_clk); #1;
    rx_ready = 1'b0;
    tests_run++;
    if ({f_rx_ack, s_rx_ack, m_rx_ack} !== 3'b111) begin
      tests_failed++; $display("FAIL rx_ack: got %b expected 111", {f_rx_ack, s_rx_ack, m_rx_ack});
    end
    tests_run++;
    if ({f_match_pulse, m_match_pulse, s_match_pulse} !== {ef, ef, es}) begin
      tests_failed++;
      $display("FAIL match_pulse byte %h: got f/m/s=%b expected %b", b, {f_match_pulse, m_match_pulse, s_match_pulse}, {ef, ef, es});
    end
    repeat (gap) @(posedge system_clk);
  endtask

  task automatic send_buf();
    for (int i = 0; i < flen; i++) send_byte(fbuf[i], $urandom_range(2, 4));
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) fbuf[i] = s[i];
    flen = s.len();
  endtask

  task automatic cs_fall();
    @(posedge system_clk); #1;
    spi_cs_n = 1'b0;
    fr_armed = 1'b1;
    fr_buf.delete();
    repeat (4) @(posedge system_clk);
  endtask

  task automatic cs_rise();
    @(posedge system_clk); #1;
    spi_cs_n = 1'b1;
    fr_armed = 1'b0;
    repeat (4) @(posedge system_clk);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge system_clk); #1;
      if (f_fifo_level == 0 && s_fifo_level == 0 && m_fifo_level == 0 && !f_tx_start && !s_tx_start && !m_tx_start) break;
    end
    repeat (4) @(posedge system_clk);
    #1;
    tests_run++;
    if (k == 300 || q_f.size() != 0 || q_s.size() != 0 || q_m.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: cycles=%0d left f/s/m=%0d/%0d/%0d required 0", k, q_f.size(), q_s.size(), q_m.size());
    end
  endtask

  task automatic check_counts(input string tag);
    tests_run++;
    if (cnt_pf != exp_pf || cnt_pm != exp_pf || cnt_ps != exp_ps) begin
      tests_failed++;
      $display("FAIL %s pulse count: f/m/s=%0d/%0d/%0d expected %0d/%0d/%0d", tag, cnt_pf, cnt_pm, cnt_ps, exp_pf, exp_pf, exp_ps);
    end
    tests_run++;
    if ({f_match_sticky, m_match_sticky, s_match_sticky} !== {exp_sticky_f, exp_sticky_f, exp_sticky_s}) begin
      tests_failed++;
      $display("FAIL %s sticky: got %b expected %b", tag, {f_match_sticky, m_match_sticky, s_match_sticky}, {exp_sticky_f, exp_sticky_f, exp_sticky_s});
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests_run++;
    if ({f_rx_ack, f_tx_start, f_match_pulse, f_match_sticky, f_overflow, f_tx_data, f_fifo_level} !== '0 ||
        {s_rx_ack, s_tx_start, s_match_pulse, s_match_sticky, s_overflow, s_tx_data, s_fifo_level} !== '0 ||
        {m_rx_ack, m_tx_start, m_match_pulse, m_match_sticky, m_overflow, m_tx_data, m_fifo_level} !== '0) begin
      tests_failed++;
      $display("FAIL %s: outputs not all zero f_data=%h f_lvl=%0d f_start=%b m_lvl=%0d", tag, f_tx_data, f_fifo_level, f_tx_start, m_fifo_level);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_cs_n = 1'b1; rx_data = '0; rx_ready = 1'b0; tx_ready = 1'b1; match_clear = 1'b0;
    repeat (3) @(posedge system_clk);
    #1;
    check_all_zero("reset");
    @(negedge system_clk);
    reset = 1'b0;
    repeat (2) @(posedge system_clk);
  endtask

  task automatic test_frame_match();
    cs_fall();
    load_str(pat_f);
    send_buf();
    cs_rise();
    wait_drain();
    check_counts("frame_match");
    tests_run++;
    if (exp_pf != 1) begin tests_failed++; $display("FAIL frame_match model count: got %0d required 1", exp_pf); end
  endtask

  task automatic test_frame_corrupt();
    int p;
    cs_fall(); load_str(pat_f); fbuf[5] = 8'h58; send_buf(); cs_rise();
    cs_fall(); load_str(pat_f); p = $urandom_range(0, 15);
    fbuf[p] = fbuf[p] ^ 8'($urandom_range(1, 255)); send_buf(); cs_rise();
    cs_fall(); load_str(pat_f); send_buf(); cs_rise();
    wait_drain();
    check_counts("frame_corrupt");
    @(posedge system_clk); #1; match_clear = 1'b1;
    @(posedge system_clk); #1; match_clear = 1'b0;
    exp_sticky_f = 1'b0; exp_sticky_s = 1'b0;
    check_counts("match_clear");
  endtask

  task automatic test_truncated();
    cs_fall(); load_str(pat_f); flen = 10; send_buf(); cs_rise();
    cs_fall(); load_str(pat_f);
    for (int i = 16; i < 19; i++) fbuf[i] = 8'($urandom_range(0, 255));
    flen = 19;
    send_buf(); cs_rise();
    wait_drain();
    check_counts("truncated");
  endtask

  task automatic test_sliding();
    load_str("xababa");
    send_buf();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       fbuf[i] = 8'h61;
        1:       fbuf[i] = 8'h62;
        default: fbuf[i] = 8'h78;
      endcase
    end
    flen = 40;
    send_buf();
    wait_drain();
    check_counts("sliding");
  endtask

  task automatic test_overflow();
    int starts[4];
    int n, cyc;
    @(posedge system_clk); #1; tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 0);
    repeat (2) @(posedge system_clk);
    #1;
    tests_run++;
    if (m_fifo_level !== 3'd4 || m_overflow !== exp_ovf_m || exp_ovf_m !== 1'b1) begin
      tests_failed++; $display("FAIL overflow small: level=%0d ovf=%b required 4/1", m_fifo_level, m_overflow);
    end
    tests_run++;
    if (f_fifo_level !== 5'd6 || f_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL overflow big: level=%0d ovf=%b required 6/0", f_fifo_level, f_overflow);
    end
    tx_ready = 1'b1;
    n = 0;
    for (cyc = 0; cyc < 60 && !(n == 4 && m_fifo_level == 0); cyc++) begin
      @(posedge system_clk); #1;
      if (m_tx_start && n < 4) begin starts[n] = cyc; n++; end
    end
    tests_run++;
    if (n != 4 || m_fifo_level != 0) begin
      tests_failed++; $display("FAIL overflow drain: starts=%0d level=%0d required 4/0", n, m_fifo_level);
    end
    for (int i = 1; i < 4; i++) begin
      tests_run++;
      if (n == 4 && starts[i] - starts[i-1] != 3) begin
        tests_failed++; $display("FAIL tx_start spacing %0d: got %0d required 3", i, starts[i] - starts[i-1]);
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    @(posedge system_clk); #1; tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 2);
    #1;
    tests_run++;
    if (f_fifo_level !== 5'd3 || m_fifo_level !== 3'd3) begin
      tests_failed++; $display("FAIL mid level: f=%0d m=%0d required 3", f_fifo_level, m_fifo_level);
    end
    @(posedge system_clk); #1; tx_ready = 1'b1;
    @(posedge system_clk); #1;
    tests_run++;
    if (f_tx_start !== 1'b1 || m_tx_start !== 1'b1) begin
      tests_failed++; $display("FAIL mid issue: tx_start f/m=%b%b required 11", f_tx_start, m_tx_start);
    end
    reset = 1'b1;
    #1;
    q_f.delete(); q_s.delete(); q_m.delete();
    fr_armed = 1'b0; fr_buf.delete(); sl_win.delete();
    exp_sticky_f = 1'b0; exp_sticky_s = 1'b0; exp_ovf_m = 1'b0;
    check_all_zero("reset_mid");
    repeat (2) @(posedge system_clk);
    @(negedge system_clk);
    reset = 1'b0;
    @(posedge system_clk); #1;
    tests_run++;
    if (f_fifo_level !== 0 || m_fifo_level !== 0 || f_tx_start !== 1'b0 || m_tx_start !== 1'b0) begin
      tests_failed++; $display("FAIL post reset: f_lvl=%0d m_lvl=%0d starts=%b%b", f_fifo_level, m_fifo_level, f_tx_start, m_tx_start);
    end
    load_str(pat_f); send_buf();
    cs_fall(); load_str(pat_f); send_buf(); cs_rise();
    wait_drain();
    check_counts("reset_mid");
    tests_run++;
    if (m_overflow !== exp_ovf_m) begin
      tests_failed++; $display("FAIL post reset overflow: got %b required %b", m_overflow, exp_ovf_m);
    end
  endtask

  initial begin
    test_reset();
    test_frame_match();
    test_frame_corrupt();
    test_truncated();
    test_sliding();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
